// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin arbiter that lets NUM_REQ filter stages
// share one two-stage pipelined signed multiplier with fixed-point
// dequantization (product >>> FRAC_BITS, truncated to DATA_WIDTH).
// Optional burst lock is compiled in with `define MULT_ARB_LOCK_EN.
module mult_share_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 10,
  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] b,
  input  logic [NUM_REQ-1:0]            lock,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          res_valid,
  output logic [DATA_WIDTH-1:0]         res_data,
  output logic [ID_W-1:0]               res_id
);

  logic [ID_W-1:0]               ptr;
  logic                          rr_found;
  logic [ID_W-1:0]               rr_idx;
  logic                          sel_valid;
  logic [ID_W-1:0]               sel_idx;
  logic                          v1;
  logic [ID_W-1:0]               id1;
  logic signed [DATA_WIDTH-1:0]  a1;
  logic signed [DATA_WIDTH-1:0]  b1;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [2*DATA_WIDTH-1:0] prod_shr;

  // Successor of index k in the rotation, wrapping to 0.
  function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] k);
    return (int'(k) == NUM_REQ - 1) ? '0 : k + 1'b1;
  endfunction

  // Round-robin search: first asserted req starting at ptr, wrapping around.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned, which would infer a latch.
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      logic [ID_W-1:0] cand;
      cand = ID_W'((int'(ptr) + off) % NUM_REQ);
      if (!rr_found && req[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

`ifdef MULT_ARB_LOCK_EN
  logic            locked;
  logic [ID_W-1:0] owner;

  // While locked only the owner can be granted; otherwise round robin.
  always_comb begin
    sel_valid = rr_found;
    sel_idx   = rr_idx;
    if (locked) begin
      sel_valid = req[owner];
      sel_idx   = owner;
    end
  end

  // Pointer and lock state: a locked grant holds ptr; release advances past owner.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr    <= '0;
      locked <= 1'b0;
      owner  <= '0;
    end else if (locked) begin
      if (!(req[owner] && lock[owner])) begin
        locked <= 1'b0;
        ptr    <= next_idx(owner);
      end
    end else if (sel_valid) begin
      if (lock[sel_idx]) begin
        locked <= 1'b1;
        owner  <= sel_idx;
      end else begin
        ptr <= next_idx(sel_idx);
      end
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^lock;

  // Pure round robin: the winner is the chosen requester.
  always_comb begin
    sel_valid = rr_found;
    sel_idx   = rr_idx;
  end

  // Pointer moves one past the granted requester.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset) begin
      ptr <= '0;
    end else if (sel_valid) begin
      ptr <= next_idx(sel_idx);
    end
  end
`endif

  // One-hot grant, forced low while reset is held.
  always_comb begin
    gnt = '0;
    if (reset && sel_valid) gnt[sel_idx] = 1'b1;
  end

  // Stage 1: capture the granted requester's operands and index.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v1  <= 1'b0;
      id1 <= '0;
      a1  <= '0;
      b1  <= '0;
    end else begin
      v1 <= sel_valid;
      if (sel_valid) begin
        id1 <= sel_idx;
        a1  <= a[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
        b1  <= b[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Full-width signed product, floor-shifted by FRAC_BITS.
  always_comb begin
    prod     = a1 * b1;
    prod_shr = prod >>> FRAC_BITS;
  end

  // Stage 2: register the truncated dequantized product with its tag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
    end else begin
      res_valid <= v1;
      res_id    <= id1;
      if (v1) res_data <= prod_shr[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter (NUM_REQ=4, DATA_WIDTH=32, FRAC_BITS=10).
module tb_mult_share_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic           clock;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] a;
  logic [N*W-1:0] b;
  logic [N-1:0]   lock;
  logic [N-1:0]   gnt;
  logic           res_valid;
  logic [W-1:0]   res_data;
  logic [1:0]     res_id;

  int checks = 0;
  int errors = 0;

  mult_share_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .FRAC_BITS(10)) dut (
    .clock(clock), .reset(reset), .req(req), .a(a), .b(b), .lock(lock),
    .gnt(gnt), .res_valid(res_valid), .res_data(res_data), .res_id(res_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic set_op(input int i, input logic [W-1:0] av, input logic [W-1:0] bv);
    a[i*W +: W] = av;
    b[i*W +: W] = bv;
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic next_cycle();
    @(posedge clock);
    #2;
  endtask

  task automatic check_res(input string tag, input logic v, input logic [W-1:0] d, input logic [1:0] id);
    check({tag, "_valid"}, 64'(res_valid), 64'(v));
    if (v) begin
      check({tag, "_data"}, 64'(res_data), 64'(d));
      check({tag, "_id"}, 64'(res_id), 64'(id));
    end
  endtask

  logic [N-1:0] exp_lock [5];

  initial begin
    reset = 1'b0;
    req   = '0;
    a     = '0;
    b     = '0;
    lock  = '0;
`ifdef MULT_ARB_LOCK_EN
    exp_lock = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
`else
    exp_lock = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
`endif

    // Reset state: grant suppressed even with requests present.
    req = 4'b1111;
    #3;
    check("rst_gnt", 64'(gnt), 64'h0);
    check("rst_valid", 64'(res_valid), 64'h0);
    check("rst_data", 64'(res_data), 64'h0);
    check("rst_id", 64'(res_id), 64'h0);
    req = '0;
    @(negedge clock);
    reset = 1'b1;
    next_cycle();

    // C0: idle
    #1; check("c0_gnt", 64'(gnt), 64'h0);
    check_res("c0", 1'b0, '0, '0);
    next_cycle();

    // C1: single requester 2
    req = 4'b0100; set_op(2, 32'd1024, 32'd3072);
    #1; check("c1_gnt", 64'(gnt), 64'b0100);
    check_res("c1", 1'b0, '0, '0);
    next_cycle();

    // C2: idle, result not yet out
    req = '0;
    #1; check("c2_gnt", 64'(gnt), 64'h0);
    check_res("c2", 1'b0, '0, '0);
    next_cycle();

    // C3: ptr=3, req=1001 -> grant 3; single-requester result appears
    req = 4'b1001;
    set_op(3, -32'sd1024, 32'd3);
    set_op(0, -32'sd1, 32'd1);
    #1; check("c3_gnt", 64'(gnt), 64'b1000);
    check_res("c3", 1'b1, 32'd3072, 2'd2);
    next_cycle();

    // C4: wrap -> grant 0
    #1; check("c4_gnt", 64'(gnt), 64'b0001);
    check_res("c4", 1'b0, '0, '0);
    next_cycle();

    // C5: max positive operands on requester 1
    req = 4'b0010; set_op(1, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    #1; check("c5_gnt", 64'(gnt), 64'b0010);
    check_res("c5", 1'b1, 32'hFFFF_FFFD, 2'd3);
    next_cycle();

    req = '0;
    #1; check_res("c6", 1'b1, 32'hFFFF_FFFF, 2'd0);
    next_cycle();
    #1; check_res("c7", 1'b1, 32'hFFC0_0000, 2'd1);
    next_cycle();
    #1; check_res("c8", 1'b0, '0, '0);
    next_cycle();

    // C9: grant, then reset before its result can emerge
    req = 4'b0100; set_op(2, 32'd5, 32'd1024);
    #1; check("c9_gnt", 64'(gnt), 64'b0100);
    next_cycle();
    req = 4'b1111;
    reset = 1'b0;
    #1; check("rst2_gnt", 64'(gnt), 64'h0);
    check("rst2_valid", 64'(res_valid), 64'h0);
    check("rst2_data", 64'(res_data), 64'h0);
    for (int i = 0; i < N; i++) set_op(i, 32'((i + 1) * 1024), 32'(i + 2));
    next_cycle();
    @(negedge clock);
    reset = 1'b1;

    // All four requesting continuously: grants 0,1,2,3,0,...
    for (int j = 0; j < 8; j++) begin
      int k;
      #1;
      check($sformatf("rr%0d_gnt", j), 64'(gnt), 64'(4'b0001 << (j % 4)));
      if (j < 2) begin
        check_res($sformatf("rr%0d", j), 1'b0, '0, '0);
      end else begin
        k = (j - 2) % 4;
        check_res($sformatf("rr%0d", j), 1'b1, 32'((k + 1) * (k + 2)), 2'(k));
      end
      next_cycle();
    end

    // Move ptr to 1, then burst with lock on requester 1
    req = 4'b0001;
    #1; check("pre_lock_gnt", 64'(gnt), 64'b0001);
    next_cycle();
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      lock = (j < 3) ? 4'b0010 : 4'b0000;
      #1; check($sformatf("lock%0d_gnt", j), 64'(gnt), 64'(exp_lock[j]));
      next_cycle();
    end
    req  = '0;
    lock = '0;
    next_cycle();
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
